fetch_queue_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register in the RV32I pipeline. It owns the fetch PC and issues sequential reads to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered in a small FIFO and presented to IF/ID with a valid/ready handshake. Taken branches and jumps redirect it, which flushes any wrong-path instructions.

---
 rtl/fetch_queue_unit.sv | 197 +++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: RV32I instruction fetch stage feeding the IF/ID register.
// Owns the fetch PC, issues sequential reads to a 1-cycle-latency instruction
// memory, buffers returned words in a small FIFO and hands them to IF/ID with
// a valid/ready handshake. A taken branch/jump redirect flushes wrong-path
// entries, and any in-flight response, and reloads the fetch PC.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, adds 32-bit counters perf_fetched, perf_flushed and
//   perf_stall. When undefined, these ports and counters do not exist.
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);

    // Pointer width for the power-of-two FIFO; count needs one extra bit so
    // that a full FIFO (count == DEPTH) is representable.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    // Fetch PC and the single outstanding memory read.
    logic [31:0]   fetch_pc_reg;
    logic          inflight_reg;
    logic [31:0]   inflight_pc_reg;
    logic          drop_reg;

    // FIFO bookkeeping.
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    // FIFO storage: instruction word and its PC side by side.
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    // Last head entry shown, so the outputs hold steady while the FIFO is empty.
    logic [31:0]   hold_inst_reg;
    logic [31:0]   hold_pc_reg;

    // Combinational control.
    logic [CW:0]   occupancy;
    logic          fifo_nonempty;
    logic          issue;
    logic          enq;
    logic          deq;
    logic [31:0]   redirect_target;
    logic [31:0]   head_inst;
    logic [31:0]   head_pc;

    // Issue, enqueue and dequeue decisions for the current cycle.
    always_comb begin
        occupancy       = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
        fifo_nonempty   = (count_reg != '0);
        // Occupancy ignores a same-cycle dequeue, so an issued read always
        // finds a free slot when its data returns.
        issue           = enable & ~rst & ~redirect_valid & (occupancy < DEPTH_OCC);
        // A response arriving in a redirect cycle belongs to the wrong path.
        enq             = inflight_reg & ~drop_reg & ~redirect_valid & ~rst;
        deq             = enable & ~rst & fifo_nonempty & inst_ready & ~redirect_valid;
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        head_inst       = inst_mem[head_reg];
        head_pc         = pc_mem[head_reg];
    end

    // Output drive: memory request and IF/ID-facing head entry.
    always_comb begin
        imem_rd    = issue;
        imem_addr  = fetch_pc_reg;
        inst_valid = enable & ~rst & fifo_nonempty;
        if (rst) begin
            inst_out = 32'h0000_0000;
            pc_out   = 32'h0000_0000;
        end else if (fifo_nonempty) begin
            inst_out = head_inst;
            pc_out   = head_pc;
        end else begin
            inst_out = hold_inst_reg;
            pc_out   = hold_pc_reg;
        end
    end

    // Fetch PC, in-flight tracking and FIFO pointer/count update.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'h0000_0000;
            drop_reg        <= 1'b0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
            end
            // Marks a response that was launched before the redirect.
            drop_reg <= redirect_valid & inflight_reg;

            if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
                head_reg     <= '0;
                tail_reg     <= '0;
                count_reg    <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (enq) begin
                    tail_reg <= tail_reg + AW'(1);
                end
                if (deq) begin
                    head_reg <= head_reg + AW'(1);
                end
                case ({enq, deq})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // FIFO storage write; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail_reg] <= imem_rdata;
            pc_mem[tail_reg]   <= inflight_pc_reg;
        end
    end

    // Remember the most recently presented head for the empty-FIFO outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst_reg <= 32'h0000_0000;
            hold_pc_reg   <= 32'h0000_0000;
        end else if (fifo_nonempty) begin
            hold_inst_reg <= head_inst;
            hold_pc_reg   <= head_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushed_reg;
    logic [31:0] perf_stall_reg;
    logic [31:0] flush_amount;

    // Entries lost on a redirect: everything queued plus the in-flight read.
    always_comb begin
        flush_amount = 32'(count_reg) + {31'h0, inflight_reg};
    end

    // Performance counters; all wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= 32'h0000_0000;
            perf_flushed_reg <= 32'h0000_0000;
            perf_stall_reg   <= 32'h0000_0000;
        end else begin
            if (deq) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed_reg <= perf_flushed_reg + flush_amount;
            end
            if (inst_valid && !inst_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushed = perf_flushed_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed plus randomized stimulus for fetch_queue_unit,
// checked every cycle against a queue-based model of issued fetches.
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    // Memory contents: word at address 0 is 0; upper half differs from the
    // PC elsewhere so instruction and PC paths cannot be confused.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], 16'h0000};
    endfunction

    // Synchronous instruction memory with 1-cycle latency; junk when idle.
    always @(posedge clk) begin
        imem_rdata <= imem_rd ? mem_word(imem_addr) : $urandom;
    end

    // Reference model: every issued fetch not yet consumed or flushed, in
    // program order, tagged with the cycle it was issued.
    typedef struct packed {
        logic [31:0] pc;
        int          cyc;
    } ent_t;

    ent_t        pend_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] last_pc;
    logic [31:0] last_inst;
    int          cyc;
    int          n_pass;
    int          n_total;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;
    logic [31:0] m_stall;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model to what the next edge should produce.
    task automatic step(input bit rs, input bit en, input bit rdy, input bit rv,
                        input logic [31:0] rpc);
        bit   have;
        bit   e_valid;
        bit   e_rd;
        ent_t e;
        @(negedge clk);
        rst            = rs;
        enable         = en;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        // Data issued at cycle N is presentable from cycle N+2.
        have    = (pend_q.size() > 0) && (pend_q[0].cyc <= cyc - 2);
        e_valid = !rs && en && have;
        e_rd    = !rs && en && !rv && (pend_q.size() < DEPTH);
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
        chk("imem_rd", {31'h0, imem_rd}, {31'h0, e_rd});
        if (e_rd) chk("imem_addr", imem_addr, exp_fetch);
        if (rs) begin
            chk("pc_out_rst", pc_out, 32'h0);
            chk("inst_out_rst", inst_out, 32'h0);
        end else if (have) begin
            chk("pc_out", pc_out, pend_q[0].pc);
            chk("inst_out", inst_out, mem_word(pend_q[0].pc));
        end else begin
            chk("pc_out_hold", pc_out, last_pc);
            chk("inst_out_hold", inst_out, last_inst);
        end
`ifdef FETCH_PERF_EN
        if (!rs) begin
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_flushed", perf_flushed, m_flushed);
            chk("perf_stall", perf_stall, m_stall);
        end
`endif
        if (rs) begin
            pend_q.delete();
            exp_fetch = RESET_PC;
            last_pc   = 32'h0;
            last_inst = 32'h0;
`ifdef FETCH_PERF_EN
            m_fetched = 32'h0;
            m_flushed = 32'h0;
            m_stall   = 32'h0;
`endif
        end else begin
            if (have) begin
                last_pc   = pend_q[0].pc;
                last_inst = mem_word(pend_q[0].pc);
            end
`ifdef FETCH_PERF_EN
            if (e_valid && !rdy) m_stall = m_stall + 32'd1;
`endif
            if (rv) begin
`ifdef FETCH_PERF_EN
                m_flushed = m_flushed + 32'(pend_q.size());
`endif
                pend_q.delete();
                exp_fetch = {rpc[31:2], 2'b00};
            end else begin
                if (e_valid && rdy) begin
                    void'(pend_q.pop_front());
`ifdef FETCH_PERF_EN
                    m_fetched = m_fetched + 32'd1;
`endif
                end
                if (e_rd) begin
                    e.pc  = exp_fetch;
                    e.cyc = cyc;
                    pend_q.push_back(e);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        cyc            = 0;
        exp_fetch      = RESET_PC;
        last_pc        = 32'h0;
        last_inst      = 32'h0;
`ifdef FETCH_PERF_EN
        m_fetched      = 32'h0;
        m_flushed      = 32'h0;
        m_stall        = 32'h0;
`endif
        rst            = 1'b1;
        enable         = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset, including a redirect that reset must override.
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 1, 1, 32'h0000_0400);
        step(1, 1, 1, 0, 32'h0);

        // Streaming from RESET_PC with IF/ID always ready.
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 32'h0);

        // ID stalls for 10 cycles: queue saturates, then drains contiguously.
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++)  step(0, 1, 1, 0, 32'h0);

        // Redirect to 0x103 with three entries queued and one read in flight.
        step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++)  step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 1, 32'h0000_0103);
        for (int i = 0; i < 8; i++)  step(0, 1, 1, 0, 32'h0);

        // PC wrap across 0xFFFFFFFC -> 0x00000000.
        step(0, 1, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++)  step(0, 1, 1, 0, 32'h0);

        // Enable dropped for 5 cycles mid-stream.
        for (int i = 0; i < 5; i++)  step(0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 8; i++)  step(0, 1, 1, 0, 32'h0);

        // Back-to-back redirects: the last one wins.
        step(0, 1, 1, 1, 32'h0000_2000);
        step(0, 1, 1, 1, 32'h0000_3006);
        for (int i = 0; i < 6; i++)  step(0, 1, 1, 0, 32'h0);

        // Reset mid-stream together with a redirect.
        step(1, 1, 1, 1, 32'h0000_0500);
        for (int i = 0; i < 6; i++)  step(0, 1, 1, 0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          rs;
            bit          en;
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rs  = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 99) < 70);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            step(rs, en, rdy, rv, rpc);
        end

        // Final drain.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
